// File: rtl/core_pkg.sv
// Shared RV32 core definitions: opcodes, funct7 codes, instruction formats and
// the decoded-field bundle handed from the decoder into the ID/EX register.
package core_pkg;

    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] JALR  = 7'b1100111;
    localparam logic [6:0] BXXX  = 7'b1100011;
    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam logic [6:0] ALI   = 7'b0010011;
    localparam logic [6:0] ALR   = 7'b0110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        INSTR_R,
        INSTR_I,
        INSTR_S,
        INSTR_B,
        INSTR_U,
        INSTR_J,
        INSTR_ILLEGAL
    } instr_type_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] next_pc;
        logic [31:0] pc_plus_imm;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rs1_en;
        logic        rs2_en;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic        jal;
        logic        jalr;
        logic        branch_may;
        logic        nextpc2reg;
        logic        alures2reg;
        logic        memory2reg;
        logic        mem_write;
        logic        muldiv;
        logic        illegal;
    } id_fields_t;

endpackage

// File: rtl/core_id_decode.sv
// Combinational RV32I(+M) decoder: classifies the instruction word, builds the
// immediate and PC arithmetic, and flags encodings the core does not execute.
module core_id_decode
    import core_pkg::*;
#(
    parameter bit M_EXT      = 1'b1,
    parameter bit SLTIU_ZEXT = 1'b0
) (
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output id_fields_t  fields
);

    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic        is_sltiu;
    instr_type_e itype;
    logic        illegal;
    logic        jal;
    logic        jalr;
    logic        branch_may;
    logic        nextpc2reg;
    logic        alures2reg;
    logic        memory2reg;
    logic        mem_write;
    logic        muldiv;
    logic [31:0] imm;
    logic        rs1_en;
    logic        rs2_en;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign is_sltiu = (opcode == ALI) && (funct3 == 3'b011);

    always_comb begin
        // NOTE: every output of this block gets a default before the case, so no path can infer a latch.
        itype      = INSTR_ILLEGAL;
        illegal    = 1'b0;
        jal        = 1'b0;
        jalr       = 1'b0;
        branch_may = 1'b0;
        nextpc2reg = 1'b0;
        alures2reg = 1'b0;
        memory2reg = 1'b0;
        mem_write  = 1'b0;
        muldiv     = 1'b0;

        case (opcode)
            LUI, AUIPC: begin
                itype      = INSTR_U;
                alures2reg = 1'b1;
            end
            JAL: begin
                itype      = INSTR_J;
                jal        = 1'b1;
                nextpc2reg = 1'b1;
            end
            JALR: begin
                itype      = INSTR_I;
                jalr       = 1'b1;
                nextpc2reg = 1'b1;
                illegal    = (funct3 != 3'b000);
            end
            BXXX: begin
                itype      = INSTR_B;
                branch_may = 1'b1;
                illegal    = funct3 inside {3'b010, 3'b011};
            end
            LOAD: begin
                itype      = INSTR_I;
                memory2reg = 1'b1;
                illegal    = funct3 inside {3'b011, 3'b110, 3'b111};
            end
            STORE: begin
                itype     = INSTR_S;
                mem_write = 1'b1;
                illegal   = (funct3 > 3'b010);
            end
            ALI: begin
                itype      = INSTR_I;
                alures2reg = 1'b1;
                // Only the shift forms carry funct7; every other OP-IMM uses those bits as immediate.
                if (funct3 == 3'b001) begin
                    illegal = (funct7 != F7_BASE);
                end else if (funct3 == 3'b101) begin
                    illegal = !(funct7 inside {F7_BASE, F7_ALT});
                end
            end
            ALR: begin
                itype      = INSTR_R;
                alures2reg = 1'b1;
                case (funct7)
                    F7_BASE:   illegal = 1'b0;
                    F7_ALT:    illegal = !(funct3 inside {3'b000, 3'b101});
                    F7_MULDIV: begin
                        muldiv  = 1'b1;
                        illegal = !M_EXT;
                    end
                    default:   illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase

        // An illegal word still flows down the pipe, but must not trigger any side effect.
        if (illegal) begin
            itype      = INSTR_ILLEGAL;
            jal        = 1'b0;
            jalr       = 1'b0;
            branch_may = 1'b0;
            nextpc2reg = 1'b0;
            alures2reg = 1'b0;
            memory2reg = 1'b0;
            mem_write  = 1'b0;
            muldiv     = 1'b0;
        end
    end

    always_comb begin
        imm = '0;
        case (itype)
            INSTR_I: imm = (is_sltiu && SLTIU_ZEXT) ? {20'b0, instr[31:20]}
                                                   : {{20{instr[31]}}, instr[31:20]};
            INSTR_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            INSTR_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            INSTR_U: imm = {instr[31:12], 12'b0};
            INSTR_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    assign rs1_en = itype inside {INSTR_R, INSTR_I, INSTR_S, INSTR_B};
    assign rs2_en = itype inside {INSTR_R, INSTR_S, INSTR_B};

    always_comb begin
        fields.pc          = pc;
        fields.next_pc     = pc + 32'd4;
        fields.pc_plus_imm = pc + imm;
        fields.imm         = imm;
        fields.rs1         = instr[19:15];
        fields.rs2         = instr[24:20];
        fields.rd          = instr[11:7];
        fields.rs1_en      = rs1_en;
        fields.rs2_en      = rs2_en;
        fields.opcode      = opcode;
        fields.funct3      = funct3;
        fields.funct7      = funct7;
        fields.jal         = jal;
        fields.jalr        = jalr;
        fields.branch_may  = branch_may;
        fields.nextpc2reg  = nextpc2reg;
        fields.alures2reg  = alures2reg;
        fields.memory2reg  = memory2reg;
        fields.mem_write   = mem_write;
        fields.muldiv      = muldiv;
        fields.illegal     = illegal;
    end

endmodule

// File: rtl/core_id_stage_pipe.sv
// Registered decode stage: ID/EX pipeline register with IF/EX handshake,
// flush, load-use interlock with bubble insertion and a saturating bubble counter.
module core_id_stage_pipe
    import core_pkg::*;
#(
    parameter bit M_EXT      = 1'b1,
    parameter bit SLTIU_ZEXT = 1'b0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_instr,
    input  logic [31:0]      i_pc,
    input  logic             i_flush,
    input  logic             i_ex_ready,
    output logic             o_valid,
    output logic [31:0]      o_pc,
    output logic [31:0]      o_next_pc,
    output logic [31:0]      o_pc_plus_imm,
    output logic [31:0]      o_imm,
    output logic [4:0]       o_rs1_addr,
    output logic [4:0]       o_rs2_addr,
    output logic [4:0]       o_dst_reg_addr,
    output logic             o_rs1_en,
    output logic             o_rs2_en,
    output logic [6:0]       o_opcode,
    output logic [6:0]       o_funct7,
    output logic [2:0]       o_funct3,
    output logic             o_jal,
    output logic             o_jalr,
    output logic             o_branch_may,
    output logic             o_nextpc2reg,
    output logic             o_alures2reg,
    output logic             o_memory2reg,
    output logic             o_mem_write,
    output logic             o_muldiv,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_bubble_cnt
);

    id_fields_t       dec;
    id_fields_t       q;
    logic             valid_q;
    logic [CNT_W-1:0] bubble_q;
    logic             hazard;
    logic             accept;

    core_id_decode #(
        .M_EXT      (M_EXT),
        .SLTIU_ZEXT (SLTIU_ZEXT)
    ) u_decode (
        .instr  (i_instr),
        .pc     (i_pc),
        .fields (dec)
    );

    // A load still in ID/EX cannot forward to the instruction behind it; hold that one back a cycle.
    assign hazard = valid_q && q.memory2reg && (q.rd != 5'd0) && i_valid &&
                    ((dec.rs1_en && (dec.rs1 == q.rd)) || (dec.rs2_en && (dec.rs2 == q.rd)));

    assign o_ready = i_flush || ((!valid_q || i_ex_ready) && !hazard);
    assign accept  = i_valid && o_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the field register is cleared along with valid so nothing stale is visible after reset.
            q        <= '0;
            valid_q  <= 1'b0;
            bubble_q <= '0;
        end else if (i_flush) begin
            // NOTE: state updates are non-blocking so every branch sees the pre-edge register values.
            valid_q <= 1'b0;
        end else if (accept) begin
            q       <= dec;
            valid_q <= 1'b1;
        end else if (hazard && i_ex_ready) begin
            valid_q <= 1'b0;
            if (bubble_q != '1) begin
                bubble_q <= bubble_q + 1'b1;
            end
        end else if (i_ex_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign o_valid        = valid_q;
    assign o_bubble_cnt   = bubble_q;
    assign o_pc           = q.pc;
    assign o_next_pc      = q.next_pc;
    assign o_pc_plus_imm  = q.pc_plus_imm;
    assign o_imm          = q.imm;
    assign o_rs1_addr     = q.rs1;
    assign o_rs2_addr     = q.rs2;
    assign o_dst_reg_addr = q.rd;
    assign o_rs1_en       = q.rs1_en;
    assign o_rs2_en       = q.rs2_en;
    assign o_opcode       = q.opcode;
    assign o_funct3       = q.funct3;
    assign o_funct7       = q.funct7;
    assign o_jal          = q.jal;
    assign o_jalr         = q.jalr;
    assign o_branch_may   = q.branch_may;
    assign o_nextpc2reg   = q.nextpc2reg;
    assign o_alures2reg   = q.alures2reg;
    assign o_memory2reg   = q.memory2reg;
    assign o_mem_write    = q.mem_write;
    assign o_muldiv       = q.muldiv;
    assign o_illegal      = q.illegal;

endmodule
